// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter unit.
// Folds sequential increment, relative branch and absolute jump into one
// register stage, and adds stall, a bounded call/return stack and fault
// reporting. The return stack is built only when the RETURN_STACK_EN macro
// is defined. Without it, CALL acts as JUMP, RET acts as HOLD and pulses
// fault, and depth/overflow/underflow read as zero.
//
// Op codes: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 HOLD, 6/7 illegal.
// There is no handshake. The control unit presents op/target/offset every
// cycle, and they are consumed on the next rising edge unless stall=1.
module pc_sequencer #(
  parameter int unsigned    W            = 16,
  parameter int unsigned    STEP         = 2,
  parameter logic [W-1:0]   RESET_VECTOR = '0,
  parameter int unsigned    DEPTH        = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [2:0]             op,
  input  logic [W-1:0]           target,
  input  logic [W-1:0]           offset,
  output logic [W-1:0]           pc,
  output logic [W-1:0]           pc_link,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   fault
);

  localparam int unsigned  DW     = $clog2(DEPTH) + 1;
  localparam logic [W-1:0] STEP_W = W'(STEP);

  localparam logic [2:0] OP_SEQ    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HOLD   = 3'd5;

  logic [W-1:0] pc_q, pc_d;
  logic         fault_q, fault_d;

`ifdef RETURN_STACK_EN
  localparam int unsigned AW = $clog2(DEPTH);

  // Circular buffer. ptr_q is the next write slot, and ptr_q-1 is the top.
  // When the buffer is full, ptr_q also addresses the oldest entry, so a
  // push overwrites the oldest entry without any extra bookkeeping.
  logic [W-1:0]  stack_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d, ptr_top;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push;
  logic          full, empty;

  assign ptr_top = ptr_q - 1'b1;
  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
`endif

  // Combinational link address: the return point for CALL and the next
  // address for sequential flow.
  assign pc_link = pc_q + STEP_W;

  // Next-state decode. On stall, every _d holds its _q value and fault_d
  // is 0.
  always_comb begin
    pc_d    = pc_q;
    fault_d = 1'b0;
`ifdef RETURN_STACK_EN
    push    = 1'b0;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`endif
    if (!stall) begin
      case (op)
        OP_SEQ:    pc_d = pc_link;
        OP_BRANCH: pc_d = pc_q + offset;
        OP_JUMP:   pc_d = target;
        OP_CALL: begin
          pc_d = target;
`ifdef RETURN_STACK_EN
          push  = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (full) begin
            ovf_d   = 1'b1;
            fault_d = 1'b1;
          end else begin
            depth_d = depth_q + 1'b1;
          end
`endif
        end
        OP_RET: begin
`ifdef RETURN_STACK_EN
          if (empty) begin
            pc_d    = pc_link;
            unf_d   = 1'b1;
            fault_d = 1'b1;
          end else begin
            pc_d    = stack_q[ptr_top];
            ptr_d   = ptr_top;
            depth_d = depth_q - 1'b1;
          end
`else
          fault_d = 1'b1;
`endif
        end
        OP_HOLD:   pc_d = pc_q;
        default:   fault_d = 1'b1;
      endcase
    end
  end

  // PC and fault registers. Reset discards any pending update.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

`ifdef RETURN_STACK_EN
  // Stack bookkeeping: pointer, occupancy and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage. It has no reset because the contents are qualified by
  // depth_q.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      stack_q[ptr_q] <= pc_link;
    end
  end

  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign depth     = '0;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign pc    = pc_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (W=16, STEP=2,
// RESET_VECTOR=0, DEPTH=4). Expectations for the stack ops follow the
// RETURN_STACK_EN macro, so the same bench serves both builds.
module tb_pc_sequencer;

  localparam int W     = 16;
  localparam int STEP  = 2;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam int EW    = 2 * W + DW + 3;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic [2:0]    op = 3'd5;
  logic [W-1:0]  target = '0;
  logic [W-1:0]  offset = '0;
  logic [W-1:0]  pc, pc_link;
  logic [DW-1:0] depth;
  logic          overflow, underflow, fault;

  always #5 clock = ~clock;

  pc_sequencer #(.W(W), .STEP(STEP), .RESET_VECTOR('0), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .stall(stall), .op(op),
    .target(target), .offset(offset), .pc(pc), .pc_link(pc_link),
    .depth(depth), .overflow(overflow), .underflow(underflow), .fault(fault)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_stk[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic         m_fault = 1'b0;

  task automatic model_step(input logic rst, input logic stl, input logic [2:0] o,
                            input logic [W-1:0] tg, input logic [W-1:0] of);
    logic [W-1:0] link;
    link = m_pc + W'(STEP);
    m_fault = 1'b0;
    if (rst) begin
      m_pc = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stl) begin
      case (o)
        3'd0: m_pc = link;
        3'd1: m_pc = m_pc + of;
        3'd2: m_pc = tg;
        3'd3: begin
`ifdef RETURN_STACK_EN
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
            m_fault = 1'b1;
          end
          m_stk.push_back(link);
`endif
          m_pc = tg;
        end
        3'd4: begin
`ifdef RETURN_STACK_EN
          if (m_stk.size() == 0) begin
            m_pc = link;
            m_unf = 1'b1;
            m_fault = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
`else
          m_fault = 1'b1;
`endif
        end
        3'd5: ;
        default: m_fault = 1'b1;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  // Drive one cycle of stimulus, queue the expected outcome, and compare
  // it #1 after the consuming edge.
  task automatic drive(input logic rst, input logic stl, input logic [2:0] o,
                       input logic [W-1:0] tg, input logic [W-1:0] of);
    logic [EW-1:0] e;
    logic [W-1:0]  e_pc, e_link;
    logic [DW-1:0] e_depth;
    logic          e_ovf, e_unf, e_fault;
    @(negedge clock);
    reset = rst; stall = stl; op = o; target = tg; offset = of;
    model_step(rst, stl, o, tg, of);
    exp_q.push_back({m_pc, m_pc + W'(STEP), DW'(m_stk.size()), m_ovf, m_unf, m_fault});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      {e_pc, e_link, e_depth, e_ovf, e_unf, e_fault} = e;
      check("pc", 32'(pc), 32'(e_pc));
      check("pc_link", 32'(pc_link), 32'(e_link));
      check("depth", 32'(depth), 32'(e_depth));
      check("overflow", 32'(overflow), 32'(e_ovf));
      check("underflow", 32'(underflow), 32'(e_unf));
      check("fault", 32'(fault), 32'(e_fault));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset while a JUMP is presented; reset must win.
    drive(1, 0, 3'd2, 16'h0100, 16'h0);
    drive(1, 0, 3'd2, 16'h0100, 16'h0);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_fault", 32'(fault), 32'h0);

    // Sequential flow: 2,4,...,16.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 3'd0, 16'h0, 16'h0);
      check("seq_pc", 32'(pc), 32'(2 * (i + 1)));
    end

    // Backward branch.
    drive(0, 0, 3'd2, 16'h0010, 16'h0);
    drive(0, 0, 3'd1, 16'h0, 16'hFFF8);
    check("branch_back", 32'(pc), 32'h0008);

    // Silent wrap-around.
    drive(0, 0, 3'd2, 16'hFFFE, 16'h0);
    check("link_at_top", 32'(pc_link), 32'h0000);
    drive(0, 0, 3'd0, 16'h0, 16'h0);
    check("wrap_pc", 32'(pc), 32'h0000);
    check("wrap_fault", 32'(fault), 32'h0);

    // CALL then RET returns to the link address.
    drive(0, 0, 3'd2, 16'h0020, 16'h0);
    drive(0, 0, 3'd3, 16'h0400, 16'h0);
    check("call_pc", 32'(pc), 32'h0400);
    drive(0, 0, 3'd4, 16'h0, 16'h0);

    // Overflow: 5 CALLs from pc=0, then 4 RETs.
    drive(1, 0, 3'd5, 16'h0, 16'h0);
    for (int i = 1; i <= 5; i++) drive(0, 0, 3'd3, 16'(i * 16), 16'h0);
    drive(0, 0, 3'd5, 16'h0, 16'h0);   // fault must drop again
    for (int i = 0; i < 4; i++) drive(0, 0, 3'd4, 16'h0, 16'h0);

    // Underflow, then illegal ops.
    drive(1, 0, 3'd5, 16'h0, 16'h0);
    drive(0, 0, 3'd2, 16'h0030, 16'h0);
    drive(0, 0, 3'd4, 16'h0, 16'h0);
    drive(0, 0, 3'd6, 16'h0, 16'h0);
    drive(0, 0, 3'd7, 16'h0, 16'h0);
    drive(0, 0, 3'd5, 16'h0, 16'h0);

    // Stall holds a CALL; then it executes once.
    for (int i = 0; i < 3; i++) drive(0, 1, 3'd3, 16'h0080, 16'h0);
    drive(0, 0, 3'd3, 16'h0080, 16'h0);
    check("call_after_stall", 32'(pc), 32'h0080);
    drive(0, 1, 3'd6, 16'h0, 16'h0);   // stalled illegal op: no fault
    drive(0, 0, 3'd4, 16'h0, 16'h0);

    // Reset during a CALL discards it.
    drive(0, 0, 3'd2, 16'h0200, 16'h0);
    drive(1, 0, 3'd3, 16'h0300, 16'h0);

    // Random traffic, including back-to-back CALL/RET.
    for (int i = 0; i < 400; i++) begin
      logic rst, stl;
      logic [2:0] o;
      rst = ($urandom_range(0, 99) == 0);
      stl = ($urandom_range(0, 9) == 0);
      o   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7))
                                         : 3'($urandom_range(0, 5));
      drive(rst, stl, o, 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE,
            16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the stimulus is bounded, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
